// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory-access stage
package mem_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // funct3[1:0] encodes access size for both loads and stores
  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the addressed byte/halfword of a load word
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(rdata >> {offset, 3'b000});
    half_sel = 16'(rdata >> {offset[1], 4'b0000});
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I memory-access stage with stall control and MEM/WB register
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_write_data,
  input  logic [XLEN-1:0] ex_pc_plus4,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic [1:0]      ex_result_src,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  output logic            mem_stall,
  output logic            dmem_req,
  input  logic            dmem_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [XLEN-1:0] wb_read_data,
  output logic [XLEN-1:0] wb_pc_plus4,
  output logic [1:0]      wb_result_src,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic            misalign_err
);

  mem_state_e      state;
  logic [1:0]      a;
  logic [1:0]      offset_q;
  logic            is_load, is_store, is_mem, legal, err, accepted;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] load_data;

  assign a        = ex_alu_result[1:0];
  assign is_load  = ex_valid && ex_mem_read;
  assign is_store = ex_valid && ex_mem_write && !ex_mem_read;
  assign is_mem   = is_load || is_store;
  assign legal    = is_load ? (ex_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                            : (ex_funct3 inside {F3_B, F3_H, F3_W});
  assign err      = is_mem && (!legal || access_misaligned(ex_funct3, a));

  assign dmem_req  = rst_n && (state == IDLE) && is_mem && !err;
  assign dmem_we   = dmem_req && is_store;
  assign dmem_addr = {ex_alu_result[XLEN-1:2], 2'b00};
  assign accepted  = dmem_req && dmem_ready;

  always_comb begin
    dmem_wdata = ex_write_data;
    lane_be    = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        dmem_wdata = {4{ex_write_data[7:0]}};
        lane_be    = 4'b0001 << a;
      end
      2'b01: begin
        dmem_wdata = {2{ex_write_data[15:0]}};
        lane_be    = 4'b0011 << a;
      end
      default: ;
    endcase
    dmem_be = 4'b0000;
    if (dmem_req) dmem_be = is_store ? lane_be : 4'b1111;
  end

  // Accepted stores retire immediately; loads keep the stage stalled until rvalid
  always_comb begin
    mem_stall = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    mem_stall = dmem_req && !(dmem_ready && is_store);
        WAIT:    mem_stall = !dmem_rvalid;
        default: mem_stall = 1'b0;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (offset_q),
    .funct3 (ex_funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      offset_q      <= 2'b00;
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus4   <= '0;
      wb_result_src <= 2'b00;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus4   <= '0;
      wb_result_src <= 2'b00;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
      misalign_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accepted && is_load) begin
            state    <= WAIT;
            offset_q <= a;
          end else if (ex_valid && (!is_mem || err || accepted)) begin
            wb_valid      <= 1'b1;
            wb_alu_result <= ex_alu_result;
            wb_pc_plus4   <= ex_pc_plus4;
            wb_result_src <= ex_result_src;
            wb_rd         <= ex_rd;
            wb_reg_write  <= ex_reg_write && !err;
            misalign_err  <= err;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state         <= IDLE;
            wb_valid      <= 1'b1;
            wb_alu_result <= ex_alu_result;
            wb_read_data  <= load_data;
            wb_pc_plus4   <= ex_pc_plus4;
            wb_result_src <= ex_result_src;
            wb_rd         <= ex_rd;
            wb_reg_write  <= ex_reg_write;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed table-driven bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_result, ex_write_data, ex_pc_plus4;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic [1:0]  ex_result_src;
  logic        ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        mem_stall, dmem_req, dmem_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus4;
  logic [1:0]  wb_result_src;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_write_data(ex_write_data), .ex_pc_plus4(ex_pc_plus4), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
    .wb_read_data(wb_read_data), .wb_pc_plus4(wb_pc_plus4), .wb_result_src(wb_result_src),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .misalign_err(misalign_err)
  );

  typedef struct {
    logic        valid;
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  src;
    logic        mr, mw;
    logic [2:0]  f3;
    logic        ready;
    logic        e_req, e_stall;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_wbv, e_rw, e_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_alu_result = 0; ex_write_data = 0; ex_pc_plus4 = 0; ex_rd = 0;
    ex_reg_write = 0; ex_result_src = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                         input int gap, input logic [31:0] exp, input string nm);
    @(negedge clk);
    ex_valid = 1; ex_alu_result = addr; ex_pc_plus4 = 32'h400; ex_rd = 5'd9; ex_reg_write = 1;
    ex_result_src = 2'b01; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = f3; dmem_ready = 1;
    dmem_rvalid = 0;
    #1;
    chk({nm, " acc req"}, 32'(dmem_req), 1);
    chk({nm, " acc stall"}, 32'(mem_stall), 1);
    chk({nm, " acc be"}, 32'(dmem_be), 32'hF);
    chk({nm, " acc we"}, 32'(dmem_we), 0);
    @(posedge clk); #1;
    chk({nm, " acc wbv"}, 32'(wb_valid), 0);
    for (int k = 0; k < gap; k++) begin
      @(negedge clk); dmem_ready = 0; #1;
      chk({nm, " wait req"}, 32'(dmem_req), 0);
      chk({nm, " wait stall"}, 32'(mem_stall), 1);
      @(posedge clk); #1;
      chk({nm, " wait wbv"}, 32'(wb_valid), 0);
    end
    @(negedge clk); dmem_rvalid = 1; dmem_rdata = rdata; #1;
    chk({nm, " rv stall"}, 32'(mem_stall), 0);
    @(posedge clk); #1;
    chk({nm, " wbv"}, 32'(wb_valid), 1);
    chk({nm, " rdata"}, wb_read_data, exp);
    chk({nm, " src"}, 32'(wb_result_src), 32'h1);
    chk({nm, " rd"}, 32'(wb_rd), 9);
    chk({nm, " rw"}, 32'(wb_reg_write), 1);
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    //          valid alu           wd            pc4           rd  rw src   mr mw f3     rdy req stl be      wdata         wbv rw err
    vecs[0]  = '{1, 32'h0000_1234, 32'h0,        32'h0,        5,  1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 32'h0,        1, 1, 0};
    vecs[1]  = '{1, 32'h0000_0055, 32'h0,        32'h0,        7,  1, 2'b11, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 32'h0,        1, 1, 0};
    vecs[2]  = '{1, 32'h0000_0100, 32'h0,        32'h0000_0104,1,  1, 2'b10, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 32'h0,        1, 1, 0};
    vecs[3]  = '{1, 32'h0000_2001, 32'h0,        32'h0,        3,  1, 2'b01, 1, 0, 3'b010, 1, 0, 0, 4'b0000, 32'h0,        1, 0, 1};
    vecs[4]  = '{1, 32'h0000_0077, 32'h0,        32'h0,        4,  1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 32'h0,        1, 1, 0};
    vecs[5]  = '{1, 32'h0000_2003, 32'h0,        32'h0,        6,  1, 2'b01, 1, 0, 3'b001, 1, 0, 0, 4'b0000, 32'h0,        1, 0, 1};
    vecs[6]  = '{1, 32'h0000_3002, 32'h1111_2222,32'h0,        0,  0, 2'b00, 0, 1, 3'b010, 1, 0, 0, 4'b0000, 32'h0,        1, 0, 1};
    vecs[7]  = '{1, 32'h0000_3000, 32'h1111_2222,32'h0,        0,  0, 2'b00, 0, 1, 3'b100, 1, 0, 0, 4'b0000, 32'h0,        1, 0, 1};
    vecs[8]  = '{1, 32'h0000_3000, 32'h0,        32'h0,        8,  1, 2'b01, 1, 0, 3'b011, 1, 0, 0, 4'b0000, 32'h0,        1, 0, 1};
    vecs[9]  = '{1, 32'h0000_1002, 32'h1234_ABCD,32'h0,        0,  0, 2'b00, 0, 1, 3'b001, 1, 1, 0, 4'b1100, 32'hABCD_ABCD,1, 0, 0};
    vecs[10] = '{1, 32'h0000_1004, 32'hDEAD_BEEF,32'h0,        0,  0, 2'b00, 0, 1, 3'b010, 1, 1, 0, 4'b1111, 32'hDEAD_BEEF,1, 0, 0};
    vecs[11] = '{1, 32'h0000_1001, 32'h0000_005A,32'h0,        0,  0, 2'b00, 0, 1, 3'b000, 1, 1, 0, 4'b0010, 32'h5A5A_5A5A,1, 0, 0};
    vecs[12] = '{0, 32'h0000_0999, 32'h0,        32'h0,        2,  1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 32'h0,        0, 0, 0};
    vecs[13] = '{1, 32'h0000_2001, 32'h0,        32'h0,        5,  1, 2'b01, 1, 0, 3'b101, 1, 0, 0, 4'b0000, 32'h0,        1, 0, 1};

    idle_inputs();
    rst_n = 0;
    // A legal load presented during reset must not leak out
    ex_valid = 1; ex_alu_result = 32'h2000; ex_mem_read = 1; ex_funct3 = 3'b010; dmem_ready = 1;
    ex_reg_write = 1; ex_rd = 5'd3;
    @(posedge clk); @(negedge clk); #1;
    chk("rst req", 32'(dmem_req), 0);
    chk("rst stall", 32'(mem_stall), 0);
    chk("rst be", 32'(dmem_be), 0);
    chk("rst wbv", 32'(wb_valid), 0);
    chk("rst rw", 32'(wb_reg_write), 0);
    chk("rst err", 32'(misalign_err), 0);
    idle_inputs();
    rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ex_valid = vecs[i].valid; ex_alu_result = vecs[i].alu; ex_write_data = vecs[i].wd;
      ex_pc_plus4 = vecs[i].pc4; ex_rd = vecs[i].rd; ex_reg_write = vecs[i].rw;
      ex_result_src = vecs[i].src; ex_mem_read = vecs[i].mr; ex_mem_write = vecs[i].mw;
      ex_funct3 = vecs[i].f3; dmem_ready = vecs[i].ready;
      #1;
      chk($sformatf("v%0d req", i), 32'(dmem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d stall", i), 32'(mem_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d be", i), 32'(dmem_be), 32'(vecs[i].e_be));
      chk($sformatf("v%0d we", i), 32'(dmem_we), 32'(vecs[i].e_req && vecs[i].mw));
      chk($sformatf("v%0d addr", i), dmem_addr, {vecs[i].alu[31:2], 2'b00});
      if (vecs[i].e_req) chk($sformatf("v%0d wdata", i), dmem_wdata, vecs[i].e_wdata);
      @(posedge clk); #1;
      chk($sformatf("v%0d wbv", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
      chk($sformatf("v%0d wbrw", i), 32'(wb_reg_write), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d err", i), 32'(misalign_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d rdata", i), wb_read_data, 0);
      chk($sformatf("v%0d rd", i), 32'(wb_rd), vecs[i].e_wbv ? 32'(vecs[i].rd) : 0);
      chk($sformatf("v%0d alu", i), wb_alu_result, vecs[i].e_wbv ? vecs[i].alu : 0);
      chk($sformatf("v%0d pc4", i), wb_pc_plus4, vecs[i].e_wbv ? vecs[i].pc4 : 0);
      chk($sformatf("v%0d src", i), 32'(wb_result_src), vecs[i].e_wbv ? 32'(vecs[i].src) : 0);
    end

    // SB with back-pressure for two cycles
    @(negedge clk);
    ex_valid = 1; ex_alu_result = 32'h1003; ex_write_data = 32'h0000_00AB; ex_rd = 5'd11;
    ex_reg_write = 0; ex_result_src = 0; ex_mem_read = 0; ex_mem_write = 1; ex_funct3 = 3'b000;
    dmem_ready = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("sb req", 32'(dmem_req), 1);
      chk("sb be", 32'(dmem_be), 32'h8);
      chk("sb wdata", dmem_wdata, 32'hABAB_ABAB);
      chk("sb addr", dmem_addr, 32'h1000);
      chk("sb stall", 32'(mem_stall), 1);
      @(posedge clk); #1;
      chk("sb bubble", 32'(wb_valid), 0);
      @(negedge clk);
    end
    dmem_ready = 1; #1;
    chk("sb acc stall", 32'(mem_stall), 0);
    chk("sb acc we", 32'(dmem_we), 1);
    @(posedge clk); #1;
    chk("sb wbv", 32'(wb_valid), 1);
    chk("sb rd", 32'(wb_rd), 11);
    @(negedge clk); idle_inputs();

    do_load(32'h2002, 3'b000, 32'h0080_0000, 2, 32'hFFFF_FF80, "lb");
    do_load(32'h2002, 3'b101, 32'h8001_0000, 0, 32'h0000_8001, "lhu");
    do_load(32'h2002, 3'b001, 32'h8001_0000, 1, 32'hFFFF_8001, "lh");
    do_load(32'h2001, 3'b100, 32'h1234_F056, 0, 32'h0000_00F0, "lbu");
    do_load(32'h2004, 3'b010, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, "lw");

    // Reset while waiting on a load; the late rvalid must be dropped
    @(negedge clk);
    ex_valid = 1; ex_alu_result = 32'h2000; ex_rd = 5'd12; ex_reg_write = 1; ex_result_src = 2'b01;
    ex_mem_read = 1; ex_funct3 = 3'b010; dmem_ready = 1;
    @(posedge clk);
    @(negedge clk); rst_n = 0; #1;
    chk("rw stall", 32'(mem_stall), 0);
    chk("rw req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    chk("rw wbv", 32'(wb_valid), 0);
    chk("rw rd", 32'(wb_rd), 0);
    @(negedge clk);
    rst_n = 1; idle_inputs(); dmem_rvalid = 1; dmem_rdata = 32'h1234_5678; #1;
    chk("rw post stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    chk("rw post wbv", 32'(wb_valid), 0);
    chk("rw post rw", 32'(wb_reg_write), 0);
    chk("rw post rdata", wb_read_data, 0);
    @(negedge clk);
    dmem_rvalid = 0; ex_valid = 1; ex_alu_result = 32'h0000_4321; ex_rd = 5'd13; ex_reg_write = 1; #1;
    chk("rw alu stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    chk("rw alu wbv", 32'(wb_valid), 1);
    chk("rw alu res", wb_alu_result, 32'h0000_4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage of the RV32I pipeline.
- Takes EX/MEM pipeline fields, issues loads and stores to data memory over a valid/ready request and response interface, and stalls the pipeline while an access is outstanding.
- Aligns and sign-extends load data.
- Registers the three writeback candidates (ALU result, load data, PC+4) plus the 2-bit result select. These feed the downstream 3:1 writeback result mux directly.

Parameters:
- XLEN, 32, datapath and address width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- ex_valid  in  1  EX/MEM slot holds a real instruction
- ex_alu_result  in  32  ALU result; also the effective address for memory ops
- ex_write_data  in  32  store data (rs2)
- ex_pc_plus4  in  32  PC+4 of the instruction
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- ex_result_src  in  2  writeback select: 00 ALU, 01 MEM, 10 PC+4, 11 reserved
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size and sign
- mem_stall  out  1  upstream must hold all ex_* inputs stable
- dmem_req  out  1  request valid
- dmem_ready  in  1  memory accepts the request this cycle
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  store data, replicated into byte lanes
- dmem_be  out  4  byte enables
- dmem_rvalid  in  1  load response valid
- dmem_rdata  in  32  load response word
- wb_valid  out  1  WB slot valid
- wb_alu_result  out  32  to result mux input 00
- wb_read_data  out  32  aligned load data, to mux input 01
- wb_pc_plus4  out  32  to mux input 10
- wb_result_src  out  2  mux select
- wb_rd  out  5  destination register
- wb_reg_write  out  1  register-file write enable
- misalign_err  out  1  one-cycle pulse, registered with the WB slot

Behaviour:

Reset:
- Reset is synchronous, active-low.
- While rst_n=0 at a rising edge:
  - state <= IDLE
  - all wb_* outputs and misalign_err <= 0
  - dmem_req, dmem_we, dmem_be and mem_stall are forced to 0 combinationally while rst_n=0.
- Reset during WAIT abandons the access. A later dmem_rvalid is ignored, because rvalid is only honoured in WAIT.

States:
- IDLE
  - Non-memory instruction (ex_valid=1, mem_read=mem_write=0): mem_stall=0. The WB register captures it at the next edge, so latency is 1 cycle.
  - Memory op, aligned: dmem_req=1 combinationally from the ex_* fields.
    - mem_stall = !(dmem_req && dmem_ready && ex_mem_write).
    - Store accepted (ready=1): completes this cycle and WB captures at the edge.
    - Load accepted: go to WAIT.
    - Not accepted: hold the request, stay in IDLE, stall=1, and WB captures a bubble (wb_valid=0).
  - Misaligned or illegal memory op:
    - No dmem_req, mem_stall=0.
    - WB captures with wb_reg_write=0 and misalign_err=1.
  - ex_valid=0: no request, and WB captures wb_valid=0.
- WAIT
  - dmem_req=0, mem_stall=1, and WB inserts bubbles.
  - On dmem_rvalid: mem_stall=0, WB captures the aligned load data, and the next state is IDLE.
- Minimum load latency is 2 cycles: acceptance, then rvalid no earlier than the following cycle.

Alignment (a = ex_alu_result[1:0]):
- Byte ops (LB, LBU, SB) are always aligned.
- Halfword ops (LH, LHU, SH) are misaligned if a[0]=1.
- Word ops (LW, SW) are misaligned if a != 0.
- funct3 011, 110, 111 are illegal for loads.
- funct3 values other than 000, 001, 010 are illegal for stores.

Store byte lanes:
- SB: be = 4'b0001 << a, wdata = {4{data[7:0]}}.
- SH: be = 4'b0011 << a, wdata = {2{data[15:0]}}.
- SW: be = 4'b1111, wdata = data.
- Loads drive be = 4'b1111.

Load extraction:
- Byte = rdata[8a+7:8a]; halfword = rdata[16a[1]+15:16a[1]].
- LB and LH sign-extend; LBU and LHU zero-extend.
- The load address offset a is held in a register across WAIT.

WB register:
- Non-load instructions: wb_read_data = 0.
- wb_result_src passes through unchanged, including the reserved value 11.
- misalign_err is high for exactly one WB cycle.

Decomposition:
- Package mem_pkg holds:
  - result_src_e (RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10)
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum mem_state_e {IDLE, WAIT}
- One sub-module, load_align: combinational (rdata, offset, funct3) -> 32-bit extended data. It is reused by any future load path.

Test Plan:
1. ALU instruction (alu_result=0x1234, rd=5, src=00), dmem idle -> next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=5, mem_stall=0 throughout.
2. SB at 0x1003, data=0xAB, dmem_ready low for 2 cycles then high -> dmem_be=4'b1000, wdata=0xABABABAB, addr=0x1000. mem_stall=1 for 2 cycles, WB bubbles, then the WB slot is valid.
3. LB at 0x2002, accept immediately, rvalid 3 cycles later with rdata=0x0080_0000 -> wb_read_data=0xFFFF_FF80, src=01. Stall spans acceptance through the cycle before rvalid.
4. LHU at 0x2002, rdata=0x8001_0000 -> wb_read_data=0x0000_8001. LH at 0x2002 with the same rdata -> 0xFFFF_8001.
5. LW at 0x2001 -> no dmem_req, misalign_err=1 for one cycle, wb_reg_write=0, no stall.
6. Load accepted, rst_n=0 during WAIT, then rvalid arrives after reset -> state IDLE, wb_* all 0, rvalid ignored, no spurious writeback.
